hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks the destination register of every in-flight instruction across `STAGES` post-decode stages and drives the forwarding mux selects for both ALU operands. It detects load-use hazards and generates stalls and bubbles, handles branch/jump flushes, and produces the 2-bit PC select for the fetch stage. It sits beside the datapath, between decode and the ALU input muxes.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight destination registers after decode, drives the
// ALU operand forwarding selects, detects load-use hazards, and arbitrates
// stall / flush / freeze into bubble and PC-select controls.
module hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int STAGES     = 2,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic              stall,
    output logic [1:0]        pc_sel,
    output logic              bubble,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_NEXT   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_RESET  = 2'd3
    } pc_sel_e;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_STALL,
        ACT_ADVANCE
    } action_e;

    // Scoreboard: index i holds post-decode stage i+1.
    logic [STAGES-1:0]             vld_q, vld_d;
    logic [STAGES-1:0]             wen_q, wen_d;
    logic [STAGES-1:0]             ld_q,  ld_d;
    logic [STAGES-1:0][ADDR_W-1:0] rd_q,  rd_d;
    logic [31:0]                   stall_cycles_q, stall_cycles_d;
    logic [31:0]                   flush_count_q,  flush_count_d;

    logic [SEL_W-1:0] sel1, sel2;
    logic             hit1, hit2;
    logic             haz1, haz2;
    logic             hazard;
    action_e          act;
    pc_sel_e          pc_sel_v;

    // Youngest matching producer per source, and whether its data is still too early.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (!hit1 && id_use_rs1 && (id_rs1 != '0) && vld_q[i] && wen_q[i] &&
                (rd_q[i] == id_rs1)) begin
                hit1 = 1'b1;
                sel1 = SEL_W'(i + 1);
                haz1 = ld_q[i] && ((int'(i) + 1) < LOAD_READY);
            end
            if (!hit2 && id_use_rs2 && (id_rs2 != '0) && vld_q[i] && wen_q[i] &&
                (rd_q[i] == id_rs2)) begin
                hit2 = 1'b1;
                sel2 = SEL_W'(i + 1);
                haz2 = ld_q[i] && ((int'(i) + 1) < LOAD_READY);
            end
        end
        hazard = id_valid && (haz1 || haz2);
    end

    // Priority arbitration: reset, freeze, flush, load-use stall, advance.
    always_comb begin
        act = ACT_ADVANCE;
        if (Reset) begin
            act = ACT_RESET;
        end else if (ext_stall) begin
            act = ACT_FREEZE;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (hazard) begin
            act = ACT_STALL;
        end
    end

    // Combinational control outputs for the current cycle.
    always_comb begin
        pc_sel_v = PC_NEXT;
        stall    = 1'b0;
        bubble   = 1'b0;
        fwd_sel1 = sel1;
        fwd_sel2 = sel2;
        case (act)
            ACT_RESET: begin
                pc_sel_v = PC_RESET;
                fwd_sel1 = '0;
                fwd_sel2 = '0;
            end
            ACT_FREEZE:  pc_sel_v = PC_HOLD;
            ACT_FLUSH: begin
                pc_sel_v = PC_BRANCH;
                bubble   = 1'b1;
            end
            ACT_STALL: begin
                pc_sel_v = PC_HOLD;
                stall    = 1'b1;
                bubble   = 1'b1;
            end
            default:     pc_sel_v = PC_NEXT;
        endcase
        pc_sel = pc_sel_v;
    end

    // Next scoreboard contents and saturating event counters.
    always_comb begin
        vld_d          = vld_q;
        wen_d          = wen_q;
        ld_d           = ld_q;
        rd_d           = rd_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((act == ACT_FLUSH) || (act == ACT_STALL) || (act == ACT_ADVANCE)) begin
            for (int unsigned i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                wen_d[i] = wen_q[i-1];
                ld_d[i]  = ld_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
            if (act == ACT_ADVANCE) begin
                vld_d[0] = id_valid;
                wen_d[0] = id_wen;
                ld_d[0]  = id_is_load;
                rd_d[0]  = id_rd;
            end else begin
                vld_d[0] = 1'b0;
                wen_d[0] = 1'b0;
                ld_d[0]  = 1'b0;
                rd_d[0]  = '0;
            end
        end
        if ((act == ACT_STALL) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((act == ACT_FLUSH) && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vld_q          <= '0;
            wen_q          <= '0;
            ld_q           <= '0;
            rd_q           <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            vld_q          <= vld_d;
            wen_q          <= wen_d;
            ld_q           <= ld_d;
            rd_q           <= rd_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule
